// File: rtl/movw_unit.sv
// MOVZ / MOVN / MOVK wide-move execution unit: two-stage valid/ready pipeline
// with MOVK base forwarding from instructions that have not yet reached the register file.
module movw_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [1:0]  hw,
    input  logic [15:0] imm16,
    input  logic [4:0]  rd_addr,
    input  logic [63:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic        illegal
);

    localparam logic [1:0] OP_MOVZ = 2'b00;
    localparam logic [1:0] OP_MOVN = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b10;
    localparam logic [1:0] OP_MOVK = 2'b11;
    localparam logic [4:0] XZR     = 5'd31;

    logic        run_reg;

    logic        s1_valid_reg;
    logic [1:0]  s1_op_reg;
    logic [1:0]  s1_hw_reg;
    logic [15:0] s1_imm_reg;
    logic [4:0]  s1_rd_reg;
    logic [63:0] s1_data_reg;

    // Result that was retiring in the very cycle S1 sampled rd_data, so rd_data cannot show it.
    logic        s1_late_valid_reg;
    logic [4:0]  s1_late_addr_reg;
    logic [63:0] s1_late_data_reg;

    logic        s2_valid_reg;
    logic        s2_wr_en_reg;
    logic        s2_illegal_reg;
    logic [4:0]  s2_addr_reg;
    logic [63:0] s2_data_reg;

    logic        s2_drain;
    logic        s1_move;
    logic        accept;
    logic [5:0]  shamt;
    logic [63:0] placed;
    logic [63:0] field_mask;
    logic [63:0] base;
    logic [63:0] result_next;
    logic        wr_en_next;

    assign s2_drain = s2_valid_reg && out_ready;
    assign s1_move  = s1_valid_reg && (!s2_valid_reg || out_ready);
    assign in_ready = run_reg && (!s1_valid_reg || s1_move);
    assign accept   = in_valid && in_ready;

    always_comb begin
        shamt       = {s1_hw_reg, 4'b0000};
        placed      = {48'd0, s1_imm_reg} << shamt;
        field_mask  = 64'h0000_0000_0000_FFFF << shamt;
        // S2 is always younger than the late copy, so it wins when both match.
        if (s2_valid_reg && s2_wr_en_reg && (s2_addr_reg == s1_rd_reg)) begin
            base = s2_data_reg;
        end else if (s1_late_valid_reg && (s1_late_addr_reg == s1_rd_reg)) begin
            base = s1_late_data_reg;
        end else begin
            base = s1_data_reg;
        end
        case (s1_op_reg)
            OP_MOVZ: result_next = placed;
            OP_MOVN: result_next = ~placed;
            OP_MOVK: result_next = (base & ~field_mask) | placed;
            default: result_next = 64'd0;
        endcase
        wr_en_next = (s1_op_reg != OP_ILL) && (s1_rd_reg != XZR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg      <= 1'b0;
            s1_op_reg         <= 2'b00;
            s1_hw_reg         <= 2'b00;
            s1_imm_reg        <= 16'd0;
            s1_rd_reg         <= 5'd0;
            s1_data_reg       <= 64'd0;
            s1_late_valid_reg <= 1'b0;
            s1_late_addr_reg  <= 5'd0;
            s1_late_data_reg  <= 64'd0;
        end else if (accept) begin
            s1_valid_reg      <= 1'b1;
            s1_op_reg         <= op;
            s1_hw_reg         <= hw;
            s1_imm_reg        <= imm16;
            s1_rd_reg         <= rd_addr;
            s1_data_reg       <= rd_data;
            s1_late_valid_reg <= s2_drain && s2_wr_en_reg;
            s1_late_addr_reg  <= s2_addr_reg;
            s1_late_data_reg  <= s2_data_reg;
        end else if (s1_move) begin
            s1_valid_reg      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_reg   <= 1'b0;
            s2_wr_en_reg   <= 1'b0;
            s2_illegal_reg <= 1'b0;
            s2_addr_reg    <= 5'd0;
            s2_data_reg    <= 64'd0;
        end else if (s1_move) begin
            s2_valid_reg   <= 1'b1;
            s2_wr_en_reg   <= wr_en_next;
            s2_illegal_reg <= (s1_op_reg == OP_ILL);
            s2_addr_reg    <= s1_rd_reg;
            s2_data_reg    <= result_next;
        end else if (s2_drain) begin
            s2_valid_reg   <= 1'b0;
        end
    end

    assign out_valid = s2_valid_reg;
    assign wr_en     = s2_valid_reg && s2_wr_en_reg;
    assign illegal   = s2_valid_reg && s2_illegal_reg;
    assign wr_addr   = s2_addr_reg;
    assign wr_data   = s2_data_reg;

endmodule

// File: tb/tb_movw_unit.sv
// Bench for movw_unit: architectural register-file model plus directed vectors
// with hand-computed results for the key scenarios.
module tb_movw_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [1:0]  hw;
    logic [15:0] imm16;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        illegal;

    typedef struct {
        logic [63:0] data;
        logic        en;
        logic [4:0]  addr;
        logic        ill;
    } res_t;

    logic [63:0] rf [32];
    logic [63:0] arch [32];
    logic        seeded = 1'b0;
    res_t        exp_q [$];
    res_t        log_q [$];
    int          acc_cnt = 0;
    int          total = 0;
    int          bad = 0;

    movw_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .hw(hw), .imm16(imm16), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file the unit writes back into; writes become visible the next cycle.
    assign rd_data = rf[rd_addr];
    always @(posedge clk) begin
        if (!seeded) begin
            for (int k = 0; k < 32; k++) rf[k] <= 64'd0;
            rf[7] <= 64'h0123_4567_89AB_CDEF;
            rf[9] <= 64'h1111_2222_3333_4444;
            seeded <= 1'b1;
        end else if (reset && out_valid && out_ready && wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    function automatic logic [79:0] pack(input res_t r);
        return {9'd0, r.ill, r.en, r.addr, r.data};
    endfunction

    // Program-order semantics: every instruction sees all older results.
    function automatic res_t model(input logic [1:0] o, input logic [1:0] h,
                                   input logic [15:0] imm, input logic [4:0] rd);
        res_t r;
        logic [63:0] field;
        logic [63:0] mask;
        field  = {48'd0, imm} << (16 * int'(h));
        mask   = 64'hFFFF << (16 * int'(h));
        r.addr = rd;
        r.ill  = (o == 2'b10);
        r.en   = !r.ill && (rd != 5'd31);
        case (o)
            2'b00:   r.data = field;
            2'b01:   r.data = ~field;
            2'b11:   r.data = (arch[rd] & ~mask) | field;
            default: r.data = 64'd0;
        endcase
        if (r.en) arch[rd] = r.data;
        return r;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {79'd0, act}, {79'd0, exp});
    endtask

    task automatic chk_log(input int idx, input string name, input logic [63:0] data,
                           input logic en, input logic [4:0] addr, input logic ill);
        if (idx < log_q.size()) begin
            chk(name, pack(log_q[idx]), {9'd0, ill, en, addr, data});
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got no result want %h", name, data);
        end
    endtask

    task automatic monitor();
        res_t cur;
        res_t prev;
        logic prev_hold;
        prev_hold = 1'b0;
        prev = '{data: 64'd0, en: 1'b0, addr: 5'd0, ill: 1'b0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                prev_hold = 1'b0;
                for (int k = 0; k < 32; k++) arch[k] = rf[k];
                chk("reset_outputs", {7'd0, in_ready, out_valid, wr_en, illegal, wr_addr, wr_data}, 80'd0);
            end else begin
                if (out_valid) begin
                    cur = '{data: wr_data, en: wr_en, addr: wr_addr, ill: illegal};
                    if (prev_hold) chk("hold_stable", pack(cur), pack(prev));
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got %h want none", pack(cur));
                    end else begin
                        chk("result", pack(cur), pack(exp_q[0]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            log_q.push_back(cur);
                        end
                    end
                    prev_hold = !out_ready;
                    prev = cur;
                end else begin
                    prev_hold = 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(op, hw, imm16, rd_addr));
                    acc_cnt++;
                end
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call only at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [1:0] h,
                         input logic [15:0] imm, input logic [4:0] rd);
        logic accepted;
        op = o; hw = h; imm16 = imm; rd_addr = rd; in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 (rd=%0d)", rd);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 2'b10; hw = 2'b11; imm16 = 16'hDEAD; rd_addr = 5'd13;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        sync();
    endtask

    int n;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b10; hw = 2'b11; imm16 = 16'hDEAD; rd_addr = 5'd13;
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog");
            end
        join_none

        #1 reset = 1'b0;
        #1;
        chk("reset_in_ready", {79'd0, in_ready}, 80'd0);
        chk("reset_state", {7'd0, out_valid, wr_en, illegal, wr_addr, wr_data, 1'b0}, 80'd0);
        #10 reset = 1'b1;
        #1 chk1("ready_before_edge", in_ready, 1'b0);
        sync();
        chk1("ready_after_edge", in_ready, 1'b1);

        // MOVZ with latency check, then MOVN
        out_ready = 1'b1;
        n = log_q.size();
        issue(2'b00, 2'd2, 16'hBEEF, 5'd3);
        @(negedge clk);
        chk1("latency_1", out_valid, 1'b0);
        @(negedge clk);
        chk1("latency_2", out_valid, 1'b1);
        wait_drain();
        issue(2'b01, 2'd0, 16'h0001, 5'd4);
        wait_drain();
        chk_log(n,     "movz_beef", 64'h0000_BEEF_0000_0000, 1'b1, 5'd3, 1'b0);
        chk_log(n + 1, "movn_1",    64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 5'd4, 1'b0);

        // Back-to-back forwarding, plain MOVK from register file, illegal and XZR
        n = log_q.size();
        issue(2'b00, 2'd0, 16'h1111, 5'd5);
        issue(2'b11, 2'd3, 16'h2222, 5'd5);
        wait_drain();
        issue(2'b11, 2'd1, 16'hAAAA, 5'd7);
        issue(2'b10, 2'd1, 16'hFFFF, 5'd6);
        issue(2'b00, 2'd0, 16'h4242, 5'd31);
        wait_drain();
        chk_log(n,     "fwd_movz", 64'h0000_0000_0000_1111, 1'b1, 5'd5, 1'b0);
        chk_log(n + 1, "fwd_movk", 64'h2222_0000_0000_1111, 1'b1, 5'd5, 1'b0);
        chk_log(n + 2, "movk_rf",  64'h0123_4567_AAAA_CDEF, 1'b1, 5'd7, 1'b0);
        chk_log(n + 3, "illegal",  64'd0,                   1'b0, 5'd6, 1'b1);
        chk_log(n + 4, "xzr",      64'h0000_0000_0000_4242, 1'b0, 5'd31, 1'b0);

        // Backpressure: out_ready low for 5 cycles, three dependent offers
        n = log_q.size();
        out_ready = 1'b0;
        fork
            begin
                issue(2'b00, 2'd1, 16'h1234, 5'd8);
                issue(2'b11, 2'd0, 16'h5678, 5'd8);
                issue(2'b11, 2'd2, 16'h9ABC, 5'd8);
            end
            begin
                int base_acc;
                base_acc = acc_cnt;
                repeat (5) @(negedge clk);
                chk1("bp_in_ready", in_ready, 1'b0);
                chk1("bp_out_valid", out_valid, 1'b1);
                chk("bp_accepted", 80'(acc_cnt - base_acc), 80'd2);
                sync();
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk_log(n,     "bp_a", 64'h0000_0000_1234_0000, 1'b1, 5'd8, 1'b0);
        chk_log(n + 1, "bp_b", 64'h0000_0000_1234_5678, 1'b1, 5'd8, 1'b0);
        chk_log(n + 2, "bp_c", 64'h0000_9ABC_1234_5678, 1'b1, 5'd8, 1'b0);

        // Dependent MOVK accepted on the very edge its producer retires
        n = log_q.size();
        out_ready = 1'b0;
        issue(2'b00, 2'd3, 16'h7777, 5'd9);
        sync();
        out_ready = 1'b1;
        issue(2'b11, 2'd0, 16'h0055, 5'd9);
        wait_drain();
        chk_log(n,     "late_x", 64'h7777_0000_0000_0000, 1'b1, 5'd9, 1'b0);
        chk_log(n + 1, "late_y", 64'h7777_0000_0000_0055, 1'b1, 5'd9, 1'b0);

        // Mixed stream against the model with a ragged out_ready pattern
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    issue(2'((i * 3) % 4), 2'(i % 4), 16'(i * 16'h1357 + 16'h0101),
                          (i % 5 == 2) ? 5'd31 : ((i % 2 == 1) ? 5'd1 : 5'd2));
                end
            end
            begin
                for (int c = 0; c < 70; c++) begin
                    sync();
                    out_ready = (c % 4 != 1) && (c % 7 != 3);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset with both stages full
        out_ready = 1'b0;
        issue(2'b00, 2'd0, 16'hAAAA, 5'd10);
        issue(2'b00, 2'd0, 16'hBBBB, 5'd11);
        #2 reset = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b0);
        chk1("midrst_wr_en", wr_en, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("post_reset_quiet", out_valid, 1'b0);
        end
        sync();
        n = log_q.size();
        issue(2'b11, 2'd1, 16'h0001, 5'd10);
        wait_drain();
        chk_log(n, "post_reset_movk", 64'h0000_0000_0001_0000, 1'b1, 5'd10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/movw_unit.md
MOVW_UNIT -- requirements
Module: movw_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low; clears all state immediately when low.
REQ-003 SHALL have port in_valid, input, 1: upstream offers an instruction.
REQ-004 SHALL have port in_ready, output, 1: unit accepts the offered instruction this cycle.
REQ-005 SHALL have port op, input, 2: operation code. 00 = MOVZ, 01 = MOVN, 11 = MOVK, 10 = illegal.
REQ-006 SHALL have port hw, input, 2: halfword select; shift = 16*hw.
REQ-007 SHALL have port imm16, input, 16: immediate.
REQ-008 SHALL have port rd_addr, input, 5: destination register.
REQ-009 SHALL have port rd_data, input, 64: current register-file value of rd_addr; used by MOVK only.
REQ-010 SHALL have port out_valid, output, 1: result is available.
REQ-011 SHALL have port out_ready, input, 1: downstream writeback accepts the result.
REQ-012 SHALL have port wr_en, output, 1: perform the register write; qualified by out_valid.
REQ-013 SHALL have port wr_addr, output, 5: write destination.
REQ-014 SHALL have port wr_data, output, 64: write value.
REQ-015 SHALL have port illegal, output, 1: the result carries an illegal-op flag; qualified by out_valid.

Function
REQ-016 SHALL implement a two-stage pipeline.
- S1 captures op, hw, imm16, rd_addr and rd_data on in_valid && in_ready.
- S2 holds the computed result.
- Minimum latency: 2 cycles from input acceptance to out_valid.
REQ-017 SHALL move S1 into S2 when S1 is valid and S2 is empty or S2 is draining this cycle (out_valid && out_ready).
REQ-018 SHALL drive in_ready = !s1_valid || (S1 moves to S2 this cycle); in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 SHALL sustain a throughput of one instruction per cycle while out_ready is held high.
REQ-020 SHALL compute MOVZ result as imm16 placed at bits [16*hw+15:16*hw], all other bits 0.
REQ-021 SHALL compute MOVN result as the bitwise NOT of the MOVZ result.
REQ-022 SHALL compute MOVK result as the base value with bits [16*hw+15:16*hw] replaced by imm16 and all other base bits kept.
REQ-023 SHALL take the MOVK base from the S2 result instead of the captured rd_data when all of the following hold at S1-to-S2 transfer; otherwise the base SHALL be the captured rd_data:
- S2 is valid and not draining this cycle, or S2 is draining but its result was not yet visible to the captured rd_data;
- S2 wr_en = 1;
- S2 wr_addr equals the S1 rd_addr.
Concretely, forwarding SHALL apply whenever the S2 instruction was accepted after S1's rd_data capture could reflect it, i.e. it is the immediately preceding instruction.
REQ-024 SHALL set wr_en = 0 when rd_addr = 31 (XZR) or op = 10; the result SHALL still flow through the pipeline and produce out_valid.
REQ-025 SHALL set illegal = 1 and wr_data = 0 for op = 10.
REQ-026 SHALL hold S2 outputs stable while out_valid && !out_ready.
REQ-027 SHALL hold S1 while it cannot move; in_ready SHALL be 0 while both S1 and S2 are full and stalled.
REQ-028 SHALL ignore op, hw, imm16, rd_addr and rd_data when in_valid = 0.

Reset
REQ-029 SHALL, while reset is low:
- drive in_ready = 0, out_valid = 0, wr_en = 0, illegal = 0, wr_addr = 0, wr_data = 0;
- clear s1_valid and s2_valid.
REQ-030 SHALL, on reset assertion mid-operation, discard all in-flight instructions with no write issued.
REQ-031 SHALL raise in_ready = 1 on the first clk edge after reset deasserts.

Verification
REQ-032 Bench SHALL cover MOVZ: op=00, hw=2, imm16=0xBEEF, rd=3 -> 2 cycles later out_valid=1, wr_data=0x0000BEEF00000000, wr_en=1, wr_addr=3.
REQ-033 Bench SHALL cover MOVN: op=01, hw=0, imm16=0x0001 -> wr_data=0xFFFFFFFFFFFFFFFE.
REQ-034 Bench SHALL cover back-to-back forwarding with out_ready=1 and rd_data held at 0:
- MOVZ rd=5, hw=0, imm=0x1111, then next cycle MOVK rd=5, hw=3, imm=0x2222;
- -> second result wr_data=0x2222000000001111.
REQ-035 Bench SHALL cover backpressure: out_ready=0 for 5 cycles with 3 offered instructions -> two instructions accepted, then in_ready=0; outputs stable; all three results delivered in order after out_ready=1.
REQ-036 Bench SHALL cover illegal/XZR:
- op=10 -> illegal=1, wr_en=0, wr_data=0;
- MOVZ rd=31 -> out_valid=1, wr_en=0.
REQ-037 Bench SHALL cover reset mid-stream: assert reset with S1 and S2 full -> out_valid=0 and in_ready=0 immediately; no stale result appears after release.
